// File: rtl/maze_timer_scan_if.sv
// ---------------------------------------------------------------------------
// maze_timer_scan_if
//   Bundle between game control and the timer/scanner, and between the
//   timer/scanner and the shared 7-segment decoder.
//
//   Control (game control -> timer):
//     start    one-cycle pulse, begin or restart timing
//     stop     one-cycle pulse, player reached exit, freeze time
//     clear    one-cycle pulse, return to idle with zero count
//   Display / status (timer -> decoder, game control):
//     digit    BCD value of the selected digit (decoder data input)
//     blank    1 = selected digit dark (decoder init input)
//     an       active-low one-hot anodes, an[k] low selects digit k (k=0 ones)
//     running  1 while timing
//     overflow sticky, count saturated at 9999
//
//   master: game-control/decoder side; slave: the timer/scanner itself.
// ---------------------------------------------------------------------------
interface maze_timer_scan_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] digit;
  logic       blank;
  logic [3:0] an;
  logic       running;
  logic       overflow;

  modport master (
    output start, stop, clear,
    input  digit, blank, an, running, overflow
  );

  modport slave (
    input  start, stop, clear,
    output digit, blank, an, running, overflow
  );
endinterface

// File: rtl/maze_timer_scan.sv
// ---------------------------------------------------------------------------
// maze_timer_scan
//   Elapsed-time counter and 4-digit display scanner for the maze game.
//   Counts whole seconds in BCD (0000..9999) from start until stop, and
//   time-multiplexes the four digits onto one shared 7-segment decoder.
//
//   Parameters:
//     TICK_DIV  clk cycles per counted second (>= 2)
//     SCAN_DIV  clk cycles each digit stays selected (>= 2)
//
//   Ports:
//     clk   system clock
//     rst   asynchronous active-high reset
//     bus   maze_timer_scan_if.slave
//             in : start, stop, clear (one-cycle pulses, clear > stop > start)
//             out: digit, blank, an (registered together), running, overflow
// ---------------------------------------------------------------------------
module maze_timer_scan #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  maze_timer_scan_if.slave  bus
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [TICK_W-1:0]     r_tick;
  logic [SCAN_W-1:0]     r_scan;
  logic [1:0]            r_sel;
  logic [3:0][3:0]       r_cnt;      // r_cnt[0] = ones ... r_cnt[3] = thousands
  logic                  r_ovf;

  logic [3:0]            r_digit;
  logic                  r_blank;
  logic [3:0]            r_an;

  logic                  w_tick_wrap;
  logic                  w_cnt_max;
  logic [3:0][3:0]       w_cnt_inc;
  logic                  w_carry;
  logic [3:0]            w_lz;
  logic                  w_blank_sel;
  logic                  w_running;
  logic                  w_idle;

  // -------------------------------------------------------------------------
  // Tick and BCD helpers
  // -------------------------------------------------------------------------
  assign w_tick_wrap = (r_state == S_RUN) && (r_tick == TICK_W'(TICK_DIV - 1));
  assign w_cnt_max   = (r_cnt == 16'h9999);

  // Ripple-carry BCD increment, ones digit first.
  always_comb begin
    w_cnt_inc = r_cnt;
    w_carry   = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      if (w_carry) begin
        if (r_cnt[k] == 4'd9) begin
          w_cnt_inc[k] = 4'd0;
        end else begin
          w_cnt_inc[k] = r_cnt[k] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state (clear > stop > start; stop only matters in RUN)
  // -------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    if (bus.clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) w_next = S_RUN;
        S_RUN: begin
          if (bus.stop) begin
            w_next = S_DONE;
          end else if (w_tick_wrap && w_cnt_max) begin
            w_next = S_DONE;
          end
        end
        S_DONE: if (bus.start) w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_running = 1'b0;
    w_idle    = 1'b0;
    case (r_state)
      S_RUN:   w_running = 1'b1;
      S_IDLE:  w_idle    = 1'b1;
      default: begin
        w_running = 1'b0;
        w_idle    = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Tick counter, BCD count and overflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else if (bus.clear) begin
      r_tick <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (bus.stop) begin
            // A tick wrap in the same cycle is discarded: count is frozen.
            r_tick <= '0;
          end else if (w_tick_wrap) begin
            r_tick <= '0;
            if (w_cnt_max) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: begin
          r_tick <= '0;
          if (bus.start) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Free-running digit scan
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_sel  <= 2'd0;
    end else if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
      r_scan <= '0;
      r_sel  <= r_sel + 2'd1;
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  // Leading-zero suppression: digit k is dark when it and every higher digit
  // is zero. The ones digit is always lit outside IDLE.
  always_comb begin
    w_lz[3] = (r_cnt[3] == 4'd0);
    w_lz[2] = w_lz[3] && (r_cnt[2] == 4'd0);
    w_lz[1] = w_lz[2] && (r_cnt[1] == 4'd0);
    w_lz[0] = 1'b0;
  end

  assign w_blank_sel = w_idle | w_lz[r_sel];

  // an, digit and blank are captured on the same edge from the same sel so
  // the decoder never sees one digit's value under another digit's anode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= 4'd0;
      r_blank <= 1'b1;
      r_an    <= 4'b1110;
    end else begin
      r_digit <= r_cnt[r_sel];
      r_blank <= w_blank_sel;
      r_an    <= ~(4'b0001 << r_sel);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.digit    = r_digit;
  assign bus.blank    = r_blank;
  assign bus.an       = r_an;
  assign bus.running  = w_running;
  assign bus.overflow = r_ovf;

endmodule

// File: doc/maze_timer_scan.md
Name: maze_timer_scan

Overview:
Elapsed-time counter and 4-digit display scanner for the maze game. It counts whole seconds in BCD from game start until the player finishes. It time-multiplexes the four digits onto a single shared 7-segment decoder, driving that decoder's 4-bit digit input and blank/init input, plus the active-low digit anodes. It sits between game control (start/finish/clear pulses) and the 7-segment decoder.

Parameters:
TICK_DIV, 100000000, clk cycles per counted second (>=2)
SCAN_DIV, 100000, clk cycles each digit stays selected (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: begin or restart timing
stop  in  1  one-cycle pulse: player reached exit, freeze time
clear  in  1  one-cycle pulse: return to idle, zero count
digit  out  4  BCD value of the currently selected digit, to decoder data input
blank  out  1  1 = selected digit dark, to decoder init input
an  out  4  active-low anode one-hot, an[k] low selects digit k (k=0 is ones)
running  out  1  1 while in RUN
overflow  out  1  sticky, set when count saturated at 9999

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous, active-high. All state is cleared immediately on rst.
- Reset values: state=IDLE; count=0000; tick counter=0; scan counter=0; sel=0; digit=0; blank=1; an=4'b1110; running=0; overflow=0.
- FSM states:
  - IDLE: count held at 0, all digits blank. start -> RUN with count=0, tick counter=0, overflow=0.
  - RUN: tick counter counts 0..TICK_DIV-1. On wrap, count increments by one in BCD with ripple carry across 4 digits (ones..thousands, each 0..9). stop -> DONE. start is ignored.
  - DONE: count frozen and shown. start -> RUN with count and tick counter reset to 0 and overflow cleared.
- Priority, every state: clear > stop > start.
  - clear -> IDLE, count=0, tick counter=0, overflow=0.
  - stop in the same cycle as a tick wrap: the increment is discarded.
  - stop outside RUN is ignored.
- Saturation: a tick wrap with count=9999 leaves count at 9999, sets overflow=1, and goes to DONE.
- Tick counter runs only in RUN. It is held at 0 in IDLE and DONE.
- Scan:
  - Scan counter runs free in all states, 0..SCAN_DIV-1.
  - On wrap, sel advances 0->1->2->3->0.
  - an, digit and blank are registered and update in the same cycle, so they are always mutually consistent.
  - Latency: outputs reflect sel and count as of the previous clock edge (1 cycle).
- Blanking:
  - IDLE: blank=1 for every digit; digit is still driven with the count value, i.e. 0.
  - RUN/DONE: digit k (k>0) is blanked when it and all higher digits are 0 (leading-zero suppression). Digit 0 is never blanked.
- running=1 exactly when state=RUN.
- Outputs never glitch between digits: an is exactly one-hot low at all times after reset.

Test Plan:
(Bench parameters: TICK_DIV=10, SCAN_DIV=4.)
1. Reset: assert rst mid-count -> outputs immediately digit=0, blank=1, an=1110, running=0, overflow=0. Release rst -> sel cycles 0,1,2,3 every 4 clks, an=1110,1101,1011,0111.
2. Timing: start, wait 37*10 clks, stop -> count frozen at 0037. Scan shows digit 7 (blank=0), 3 (blank=0), 0 (blank=1), 0 (blank=1). running=0.
3. Carry: start, run to 0099, then 10 more clks -> count 0100. During the following scan, digit 1 (tens) shows 0 with blank=0.
4. Saturation: preload by running to 9999, then one more tick -> count stays 9999, overflow=1, state DONE. A later start -> count 0000, overflow=0, running=1.
5. Priority: clear+stop+start in the same cycle during RUN -> IDLE, count 0, all blank. stop coincident with a tick wrap at 0005 -> frozen at 0005, not 0006.
6. Restart from DONE: after 0012 in DONE, start -> count restarts from 0000, reaching 0001 exactly 10 clks after the start pulse edge.
